// File: rtl/sat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sat_pkg                                                      |
// | Description : Shared definitions for the DPLL solver core: variable index  |
// |               sizing, assignment table state encoding, trail entry types  |
// |               and the imply-drain FSM state enumeration.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sat_pkg;

    localparam int VAR_W        = 9;
    localparam int NUM_VARIABLE = 128;

    // Assignment table per-variable state
    localparam logic [1:0] ASG_UNASSIGNED = 2'b00;
    localparam logic [1:0] ASG_FALSE      = 2'b01;
    localparam logic [1:0] ASG_TRUE       = 2'b10;
    localparam logic [1:0] ASG_ILLEGAL    = 2'b11;

    // Trail stack entry type
    localparam logic TRAIL_DECIDED = 1'b0;
    localparam logic TRAIL_IMPLIED = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_POP      = 3'd1,
        S_LATCH    = 3'd2,
        S_CHECK    = 3'd3,
        S_COMMIT   = 3'd4,
        S_DONE     = 3'd5,
        S_CONFLICT = 3'd6
    } drain_state_e;

endpackage
`default_nettype wire

// File: rtl/imply_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imply_drain                                                  |
// | Description : Pop-side consumer of the imply stack. Pops implied literals,|
// |               checks them against the assignment table, commits new ones  |
// |               to the table and the trail stack, and stops on an empty     |
// |               stack (done) or a contradiction (conflict).                 |
// | Ports       : clk/reset        - clock, synchronous active-low reset      |
// |               start            - begin a drain (honoured in IDLE only)    |
// |               stk_*            - imply stack pop interface and flush      |
// |               asg_rd_*         - assignment table read (1-cycle latency)  |
// |               asg_wr_*         - assignment table write                   |
// |               trail_*          - trail stack push                         |
// |               busy/done/conflict/conflict_var/impl_count - status        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module imply_drain
    import sat_pkg::*;
#(
    parameter int NUM_VARIABLE = sat_pkg::NUM_VARIABLE,
    parameter int VAR_W        = sat_pkg::VAR_W,
    parameter int CNT_W        = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stk_empty,
    input  logic             stk_val,
    input  logic [VAR_W-1:0] stk_var,
    output logic             stk_en,
    output logic             stk_rw,
    output logic             stk_flush,
    output logic [VAR_W-1:0] asg_rd_var,
    input  logic [1:0]       asg_rd_state,
    output logic             asg_wr_en,
    output logic [VAR_W-1:0] asg_wr_var,
    output logic             asg_wr_val,
    output logic             trail_push,
    output logic [VAR_W-1:0] trail_var,
    output logic             trail_val,
    output logic             trail_type,
    output logic             busy,
    output logic             done,
    output logic             conflict,
    output logic [VAR_W-1:0] conflict_var,
    output logic [CNT_W-1:0] impl_count
);

    drain_state_e     r_state;
    drain_state_e     w_state_next;
    logic [VAR_W-1:0] r_var;
    logic             r_val;
    logic [VAR_W-1:0] r_conflict_var;
    logic [CNT_W-1:0] r_impl_count;

    logic             w_idx_bad;
    logic             w_match;
    logic             w_check_conflict;
    logic             w_check_commit;

    // Index 0 is reserved and anything at or above NUM_VARIABLE is out of range.
    assign w_idx_bad = (r_var == '0) || (32'(r_var) >= NUM_VARIABLE);
    assign w_match   = ((asg_rd_state == ASG_TRUE)  &&  r_val) ||
                       ((asg_rd_state == ASG_FALSE) && !r_val);

    always_comb begin
        w_check_conflict = 1'b0;
        w_check_commit   = 1'b0;
        if (r_state == S_CHECK) begin
            if (w_idx_bad || (asg_rd_state == ASG_ILLEGAL)) begin
                w_check_conflict = 1'b1;
            end else if (asg_rd_state == ASG_UNASSIGNED) begin
                w_check_commit = 1'b1;
            end else if (!w_match) begin
                w_check_conflict = 1'b1;
            end
        end
    end

    // Strobes are qualified with reset so nothing leaks out in a reset cycle,
    // even when reset lands on a COMMIT or CONFLICT cycle.
    always_comb begin
        w_state_next = r_state;
        stk_en       = 1'b0;
        stk_flush    = 1'b0;
        asg_wr_en    = 1'b0;
        trail_push   = 1'b0;
        done         = 1'b0;
        conflict     = 1'b0;
        asg_rd_var   = r_var;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_POP;
                end
            end
            S_POP: begin
                if (stk_empty) begin
                    w_state_next = S_DONE;
                end else begin
                    stk_en       = reset;
                    w_state_next = S_LATCH;
                end
            end
            S_LATCH: begin
                // Popped data is presented this cycle; address the table
                // straight from the stack so the state arrives in CHECK.
                asg_rd_var   = stk_var;
                w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_check_conflict) begin
                    w_state_next = S_CONFLICT;
                end else if (w_check_commit) begin
                    w_state_next = S_COMMIT;
                end else begin
                    w_state_next = S_POP;
                end
            end
            S_COMMIT: begin
                asg_wr_en    = reset;
                trail_push   = reset;
                w_state_next = S_POP;
            end
            S_DONE: begin
                done         = reset;
                w_state_next = S_IDLE;
            end
            S_CONFLICT: begin
                conflict     = reset;
                stk_flush    = reset;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_var          <= '0;
            r_val          <= 1'b0;
            r_conflict_var <= '0;
            r_impl_count   <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_IDLE) && start) begin
                r_impl_count   <= '0;
                r_conflict_var <= '0;
            end
            if (r_state == S_LATCH) begin
                r_var <= stk_var;
                r_val <= stk_val;
            end
            if (w_check_conflict) begin
                r_conflict_var <= r_var;
            end
            if ((r_state == S_COMMIT) && (r_impl_count != '1)) begin
                r_impl_count <= r_impl_count + CNT_W'(1);
            end
        end
    end

    assign stk_rw       = 1'b0;
    assign asg_wr_var   = r_var;
    assign asg_wr_val   = r_val;
    assign trail_var    = r_var;
    assign trail_val    = r_val;
    assign trail_type   = TRAIL_IMPLIED;
    assign busy         = (r_state != S_IDLE);
    assign conflict_var = r_conflict_var;
    assign impl_count   = r_impl_count;

endmodule
`default_nettype wire
